// File: rtl/watchdog_pkg.sv
// Shared types and elaboration helpers for the multi-channel watchdog.
package watchdog_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FAULT} wd_state_t;

   localparam int FCNT_W = 8;

   function automatic int unsigned ms_to_cycles(input int unsigned freq, input int unsigned ms);
      return (freq / 1000) * ms;
   endfunction

   // Width that holds TIMEOUT_CYCLES-1; never below 1 bit.
   function automatic int cnt_width(input int unsigned cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/watchdog_channel.sv
// One watchdog channel: kick synchroniser, event stage, down-counter, IDLE/RUN/FAULT FSM, sticky flags.
// MULTI_WATCHDOG_FAULT_COUNT_EN adds a saturating RUN->FAULT counter.
module watchdog_channel
   import watchdog_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 500,
   parameter int unsigned WINDOW_CYCLES  = 0,
   parameter int unsigned EDGE_SENSITIVE = 1
) (
   input  logic ipClk,
   input  logic Reset,
   input  logic kick,
   input  logic enable,
   input  logic clear,
   output logic timeout,
   output logic early
`ifdef MULTI_WATCHDOG_FAULT_COUNT_EN
   ,
   output logic [FCNT_W-1:0] fault_count
`endif
);
   localparam int N = cnt_width(TIMEOUT_CYCLES);
   localparam logic [N-1:0] RELOAD = N'(TIMEOUT_CYCLES - 1);
   // A held-high level input would trip the window every cycle, so the early check is edge-mode only.
   localparam bit EARLY_EN = (WINDOW_CYCLES > 0) && (EDGE_SENSITIVE != 0);

   logic [1:0]   sync;
   logic         sync_d;
   logic         kick_evt;
   logic         early_hit;
   logic         timeout_hit;
   logic [N-1:0] count;
   wd_state_t    state;

   always_ff @(posedge ipClk) begin
      if (Reset) begin
         sync   <= '0;
         sync_d <= 1'b0;
      end else begin
         sync   <= {sync[0], kick};
         sync_d <= sync[1];
      end
   end

   assign kick_evt = (EDGE_SENSITIVE != 0) ? (sync[1] & ~sync_d) : sync[1];

   if (EARLY_EN) begin : g_early
      localparam logic [N-1:0] WIN = N'(WINDOW_CYCLES);
      logic [N-1:0] elapsed;
      assign elapsed   = RELOAD - count;
      assign early_hit = kick_evt && (elapsed < WIN);
   end else begin : g_no_early
      assign early_hit = 1'b0;
   end

   // A kick landing on Count==0 wins over the timeout.
   assign timeout_hit = !kick_evt && (count == '0);

   always_ff @(posedge ipClk) begin
      if (Reset || !enable) begin
         state   <= IDLE;
         count   <= RELOAD;
         timeout <= 1'b0;
         early   <= 1'b0;
      end else begin
         case (state)
            IDLE: state <= RUN;
            RUN: begin
               if (early_hit) begin
                  state <= FAULT;
                  early <= 1'b1;
               end else if (kick_evt) begin
                  count <= RELOAD;
               end else if (timeout_hit) begin
                  state   <= FAULT;
                  timeout <= 1'b1;
               end else begin
                  count <= count - 1'b1;
               end
            end
            FAULT: begin
               if (clear) begin
                  state   <= RUN;
                  count   <= RELOAD;
                  timeout <= 1'b0;
                  early   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MULTI_WATCHDOG_FAULT_COUNT_EN
   logic enter_fault;
   assign enter_fault = enable && (state == RUN) && (early_hit || timeout_hit);

   always_ff @(posedge ipClk) begin
      if (Reset)
         fault_count <= '0;
      else if (enter_fault && (fault_count != '1))
         fault_count <= fault_count + FCNT_W'(1);
   end
`endif

endmodule

// File: rtl/multi_watchdog.sv
// Multi-channel windowed watchdog: CHANNELS independent channels plus a registered error summary.
// Define MULTI_WATCHDOG_FAULT_COUNT_EN to expose per-channel saturating fault counters on opFaultCount.
module multi_watchdog
   import watchdog_pkg::*;
#(
   parameter int unsigned CLK_FREQUENCY  = 50000000,
   parameter int unsigned CHANNELS       = 4,
   parameter int unsigned TIMEOUT_MS     = 100,
   parameter int unsigned WINDOW_MS      = 0,
   parameter int unsigned EDGE_SENSITIVE = 1
) (
   input  logic                ipClk,
   input  logic                Reset,
   input  logic [CHANNELS-1:0] ipKick,
   input  logic [CHANNELS-1:0] ipEnable,
   input  logic [CHANNELS-1:0] ipClear,
   output logic [CHANNELS-1:0] opTimeout,
   output logic [CHANNELS-1:0] opEarly,
   output logic                opError
`ifdef MULTI_WATCHDOG_FAULT_COUNT_EN
   ,
   output logic [CHANNELS*FCNT_W-1:0] opFaultCount
`endif
);
   localparam int unsigned TIMEOUT_CYCLES = ms_to_cycles(CLK_FREQUENCY, TIMEOUT_MS);
   localparam int unsigned WINDOW_CYCLES  = ms_to_cycles(CLK_FREQUENCY, WINDOW_MS);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      watchdog_channel #(
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
         .WINDOW_CYCLES  (WINDOW_CYCLES),
         .EDGE_SENSITIVE (EDGE_SENSITIVE)
      ) u_ch (
         .ipClk       (ipClk),
         .Reset       (Reset),
         .kick        (ipKick[c]),
         .enable      (ipEnable[c]),
         .clear       (ipClear[c]),
         .timeout     (opTimeout[c]),
         .early       (opEarly[c])
`ifdef MULTI_WATCHDOG_FAULT_COUNT_EN
         ,
         .fault_count (opFaultCount[c*FCNT_W +: FCNT_W])
`endif
      );
   end

   // Registered from the flag registers, so it trails them by one edge.
   always_ff @(posedge ipClk) begin
      if (Reset)
         opError <= 1'b0;
      else
         opError <= |{opTimeout, opEarly};
   end

endmodule

// File: tb/tb_multi_watchdog.sv
// Bench for multi_watchdog: directed scenarios plus random traffic against a behavioural channel model.
module tb_multi_watchdog;
   localparam int CH  = 4;
   localparam int TO  = 500;
   localparam int WIN = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [CH-1:0] kick = '0, en = '0, clr = '0;
   logic [CH-1:0] to_a, ea_a;
   logic err_a;
   logic kick_b = 1'b0, en_b = 1'b0, clr_b = 1'b0;
   logic to_b, ea_b, err_b;
   int n_cmp = 0, n_bad = 0;

`ifdef MULTI_WATCHDOG_FAULT_COUNT_EN
   logic [CH*8-1:0] fc_a;
   logic [7:0] fc_b;
   localparam int GW = 2*CH + 1 + 8*CH;
`else
   localparam int GW = 2*CH + 1;
`endif

   always #5 clk = ~clk;

   multi_watchdog #(.CLK_FREQUENCY(100000), .CHANNELS(CH), .TIMEOUT_MS(5), .WINDOW_MS(1), .EDGE_SENSITIVE(1)) dut_a (
      .ipClk(clk), .Reset(rst), .ipKick(kick), .ipEnable(en), .ipClear(clr),
      .opTimeout(to_a), .opEarly(ea_a), .opError(err_a)
`ifdef MULTI_WATCHDOG_FAULT_COUNT_EN
      , .opFaultCount(fc_a)
`endif
   );

   multi_watchdog #(.CLK_FREQUENCY(100000), .CHANNELS(1), .TIMEOUT_MS(5), .WINDOW_MS(1), .EDGE_SENSITIVE(0)) dut_b (
      .ipClk(clk), .Reset(rst), .ipKick(kick_b), .ipEnable(en_b), .ipClear(clr_b),
      .opTimeout(to_b), .opEarly(ea_b), .opError(err_b)
`ifdef MULTI_WATCHDOG_FAULT_COUNT_EN
      , .opFaultCount(fc_b)
`endif
   );

   // Reference model of dut_a: elapsed time counts up from a kick; pin history gives the 3-edge kick latency.
   int m_st[CH];          // 0 idle, 1 running, 2 faulted
   int m_el[CH];
   logic [CH-1:0] m_to, m_ea, h0, h1, h2;
   logic m_err;
   logic [7:0] m_fc[CH];

   always @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < CH; c++) begin
            m_st[c] = 0; m_el[c] = 0; m_fc[c] = 8'd0;
         end
         m_to = '0; m_ea = '0; m_err = 1'b0; h0 = '0; h1 = '0; h2 = '0;
      end else begin
         m_err = |{m_to, m_ea};
         for (int c = 0; c < CH; c++) begin
            logic ev;
            ev = h1[c] & ~h2[c];
            if (!en[c]) begin
               m_st[c] = 0; m_el[c] = 0; m_to[c] = 1'b0; m_ea[c] = 1'b0;
            end else if (m_st[c] == 0) begin
               m_st[c] = 1; m_el[c] = 0;
            end else if (m_st[c] == 1) begin
               if (ev && m_el[c] < WIN) begin
                  m_st[c] = 2; m_ea[c] = 1'b1;
                  m_fc[c] = (m_fc[c] == 8'd255) ? 8'd255 : m_fc[c] + 8'd1;
               end else if (ev) begin
                  m_el[c] = 0;
               end else if (m_el[c] == TO - 1) begin
                  m_st[c] = 2; m_to[c] = 1'b1;
                  m_fc[c] = (m_fc[c] == 8'd255) ? 8'd255 : m_fc[c] + 8'd1;
               end else begin
                  m_el[c] = m_el[c] + 1;
               end
            end else if (clr[c]) begin
               m_st[c] = 1; m_el[c] = 0; m_to[c] = 1'b0; m_ea[c] = 1'b0;
            end
         end
         h2 = h1; h1 = h0; h0 = kick;
      end
   end

   logic [GW-1:0] got_a, exp_a;
   always_comb begin
`ifdef MULTI_WATCHDOG_FAULT_COUNT_EN
      got_a = {fc_a, to_a, ea_a, err_a};
      exp_a = {m_fc[3], m_fc[2], m_fc[1], m_fc[0], m_to, m_ea, m_err};
`else
      got_a = {to_a, ea_a, err_a};
      exp_a = {m_to, m_ea, m_err};
`endif
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (got_a !== '0) begin n_bad++; $display("FAIL reset_a got=%h want=0", got_a); end
      n_cmp++; if ({to_b, ea_b, err_b} !== 3'b000) begin n_bad++; $display("FAIL reset_b got=%b want=000", {to_b, ea_b, err_b}); end
      n_cmp++; if (got_a !== exp_a) begin n_bad++; $display("FAIL reset_model got=%h want=%h", got_a, exp_a); end
      rst = 1'b0;
   endtask

   task automatic test_timeout();
      en[0] = 1'b1;
      for (int n = 0; n <= 501; n++) begin
         @(negedge clk);
         n_cmp++; if (got_a !== exp_a) begin n_bad++; $display("FAIL t1_model n=%0d got=%h want=%h", n, got_a, exp_a); end
         n_cmp++; if (to_a[0] !== (n >= 500)) begin n_bad++; $display("FAIL t1_timeout n=%0d got=%b want=%b", n, to_a[0], n >= 500); end
         n_cmp++; if (err_a !== (n >= 501)) begin n_bad++; $display("FAIL t1_error n=%0d got=%b want=%b", n, err_a, n >= 501); end
         n_cmp++; if ({to_a[3:1], ea_a} !== 7'd0) begin n_bad++; $display("FAIL t1_others n=%0d got=%b want=0", n, {to_a[3:1], ea_a}); end
      end
   endtask

   task automatic test_clear();
      en[1] = 1'b1;
      repeat (3) @(negedge clk);
      clr = 4'b0011;
      @(negedge clk);
      clr = '0;
      n_cmp++; if ({to_a[1:0], ea_a[1:0]} !== 4'b0000) begin n_bad++; $display("FAIL t4_flags got=%b want=0000", {to_a[1:0], ea_a[1:0]}); end
      n_cmp++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL t4_err_lag got=%b want=1", err_a); end
      for (int n = 1; n <= 500; n++) begin
         @(negedge clk);
         n_cmp++; if (got_a !== exp_a) begin n_bad++; $display("FAIL t4_model n=%0d got=%h want=%h", n, got_a, exp_a); end
         n_cmp++; if (to_a[0] !== (n >= 500)) begin n_bad++; $display("FAIL t4_reload n=%0d got=%b want=%b", n, to_a[0], n >= 500); end
         if (n == 1) begin
            n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL t4_err_clr got=%b want=0", err_a); end
         end
      end
   endtask

   task automatic test_kick_periodic();
      int gap, w;
      en[1] = 1'b0;
      @(negedge clk);
      en[1] = 1'b1;
      for (int n = 0; n < 150; n++) begin
         @(negedge clk);
         n_cmp++; if (got_a !== exp_a) begin n_bad++; $display("FAIL t2_lead n=%0d got=%h want=%h", n, got_a, exp_a); end
      end
      for (int p = 0; p < 11; p++) begin
         gap = (p == 9) ? 500 : (p == 10) ? 60 : 200 + int'($urandom_range(0, 200));
         w = int'($urandom_range(1, 40));
         for (int c = 0; c < gap; c++) begin
            kick[1] = (c < w);
            @(negedge clk);
            n_cmp++; if (got_a !== exp_a) begin n_bad++; $display("FAIL t2_model p=%0d c=%0d got=%h want=%h", p, c, got_a, exp_a); end
            n_cmp++; if ({to_a[1], ea_a[1]} !== 2'b00) begin n_bad++; $display("FAIL t2_flags p=%0d c=%0d got=%b want=00", p, c, {to_a[1], ea_a[1]}); end
         end
      end
      kick[1] = 1'b0;
      en[1] = 1'b0;
   endtask

   task automatic test_early();
      en[2] = 1'b1;
      for (int n = 0; n <= 120; n++) begin
         @(negedge clk);
         n_cmp++; if (got_a !== exp_a) begin n_bad++; $display("FAIL t3_model n=%0d got=%h want=%h", n, got_a, exp_a); end
         n_cmp++; if ({to_a[2], ea_a[2]} !== {1'b0, n >= 100}) begin n_bad++; $display("FAIL t3_early99 n=%0d got=%b want=%b", n, {to_a[2], ea_a[2]}, {1'b0, n >= 100}); end
         if (n == 97) kick[2] = 1'b1;
         if (n == 104) kick[2] = 1'b0;
      end
      clr[2] = 1'b1;
      @(negedge clk);
      clr[2] = 1'b0;
      for (int n = 0; n <= 200; n++) begin
         n_cmp++; if ({to_a[2], ea_a[2]} !== 2'b00) begin n_bad++; $display("FAIL t3_early100 n=%0d got=%b want=00", n, {to_a[2], ea_a[2]}); end
         if (n == 98) kick[2] = 1'b1;
         if (n == 110) kick[2] = 1'b0;
         @(negedge clk);
         n_cmp++; if (got_a !== exp_a) begin n_bad++; $display("FAIL t3_model2 n=%0d got=%h want=%h", n, got_a, exp_a); end
      end
      en[2] = 1'b0;
   endtask

   task automatic test_disable_reset();
      en[3] = 1'b1;
      for (int n = 0; n <= 22; n++) begin
         @(negedge clk);
         n_cmp++; if (got_a !== exp_a) begin n_bad++; $display("FAIL t5_model n=%0d got=%h want=%h", n, got_a, exp_a); end
         n_cmp++; if ({to_a[3], ea_a[3]} !== {1'b0, n >= 13 && n <= 20}) begin n_bad++; $display("FAIL t5_disable n=%0d got=%b want=%b", n, {to_a[3], ea_a[3]}, {1'b0, n >= 13 && n <= 20}); end
         if (n == 10) kick[3] = 1'b1;
         if (n == 20) begin en[3] = 1'b0; kick[3] = 1'b0; end
      end
      n_cmp++; if (to_a[0] !== 1'b1) begin n_bad++; $display("FAIL t5_ch0_fault got=%b want=1", to_a[0]); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (got_a !== '0) begin n_bad++; $display("FAIL t5_reset got=%h want=0", got_a); end
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         n_cmp++; if ({to_a, ea_a, err_a} !== '0) begin n_bad++; $display("FAIL t5_after n=%0d got=%h want=0", n, {to_a, ea_a, err_a}); end
      end
      en = '0;
   endtask

   task automatic test_level();
      en_b = 1'b1;
      kick_b = 1'b1;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         n_cmp++; if ({to_b, ea_b, err_b} !== 3'b000) begin n_bad++; $display("FAIL t6_hold n=%0d got=%b want=000", n, {to_b, ea_b, err_b}); end
      end
      kick_b = 1'b0;
      for (int j = 1; j <= 503; j++) begin
         @(negedge clk);
         n_cmp++; if (to_b !== (j >= 502)) begin n_bad++; $display("FAIL t6_timeout j=%0d got=%b want=%b", j, to_b, j >= 502); end
         n_cmp++; if (err_b !== (j >= 503)) begin n_bad++; $display("FAIL t6_error j=%0d got=%b want=%b", j, err_b, j >= 503); end
      end
      n_cmp++; if (ea_b !== 1'b0) begin n_bad++; $display("FAIL t6_no_early got=%b want=0", ea_b); end
`ifdef MULTI_WATCHDOG_FAULT_COUNT_EN
      n_cmp++; if (fc_b !== 8'd1) begin n_bad++; $display("FAIL t6_fcount got=%0d want=1", fc_b); end
`endif
      en_b = 1'b0;
   endtask

   task automatic test_random();
      en = '1;
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 299) == 0) en[c] = ~en[c];
            if ($urandom_range(0, 30 << (2*c)) == 0) kick[c] = ~kick[c];
            clr[c] = ($urandom_range(0, 24) == 0);
         end
         rst = ($urandom_range(0, 999) == 0);
         @(negedge clk);
         n_cmp++; if (got_a !== exp_a) begin n_bad++; $display("FAIL rand_model n=%0d got=%h want=%h", n, got_a, exp_a); end
      end
      rst = 1'b0; en = '0; clr = '0; kick = '0;
   endtask

   initial begin
      #1000000;
      $display("FAIL tb_time_limit reached before summary");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_timeout();
      test_clear();
      test_kick_periodic();
      test_early();
      test_disable_reset();
      test_level();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
